// File: rtl/pe_weight_loader.sv
// Weight-load initiator for a ROWS x COLS MAC PE array.
// Buffers one tile of weights, waits for array idle, then shifts it down the columns.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           single-cycle tile load request (ignored while busy)
//   busy, done      busy from accepted start until done; done is a 1-cycle pulse
//   w_valid/w_ready/w_data   one row of packed weights per beat, row 0 first
//   array_idle      compute pipeline drained
//   load_weight_en  broadcast load enable to all PEs
//   col_sum_out     top in_sum of every column, zero outside LOAD
module pe_weight_loader #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int W_W   = 8,
    parameter int SUM_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*W_W-1:0]    w_data,
    input  logic                   array_idle,
    output logic                   load_weight_en,
    output logic [COLS*SUM_W-1:0]  col_sum_out
);

    localparam int CW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_IDLE,
        LOAD
    } state_t;

    state_t                 state, state_d;
    logic [CW-1:0]          fill_cnt, fill_d;
    logic [CW-1:0]          load_cnt, load_d;
    logic [CW-1:0]          rd_row;
    logic                   busy_d, done_d, ready_d, en_d;
    logic [COLS*SUM_W-1:0]  col_d;
    logic [COLS*W_W-1:0]    rd_data;
    logic [COLS*SUM_W-1:0]  rd_ext;
    logic                   accept;

    logic [COLS*W_W-1:0]    buffer [ROWS];

    assign accept = w_valid && w_ready;

    // Rows are pushed bottom row first so that after ROWS shifts
    // each PE row holds its own weight.
    assign rd_row = CW'(ROWS - 1) - load_cnt;

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_row == CW'(r)) rd_data = buffer[r];
        end
    end

    // Weights are opaque bytes: zero-extend, never sign-extend.
    always_comb begin
        rd_ext = '0;
        for (int c = 0; c < COLS; c++) begin
            rd_ext[c*SUM_W +: SUM_W] = SUM_W'(rd_data[c*W_W +: W_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (fill_cnt == CW'(r)) buffer[r] <= w_data;
            end
        end
    end

    always_comb begin
        state_d = state;
        fill_d  = fill_cnt;
        load_d  = load_cnt;
        busy_d  = busy;
        done_d  = 1'b0;
        ready_d = 1'b0;
        en_d    = 1'b0;
        col_d   = '0;
        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = FILL;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    fill_d  = '0;
                    load_d  = '0;
                end
            end
            FILL: begin
                ready_d = 1'b1;
                if (accept) begin
                    fill_d = fill_cnt + CW'(1);
                    if (fill_cnt == CW'(ROWS - 1)) begin
                        state_d = WAIT_IDLE;
                        ready_d = 1'b0;
                    end
                end
            end
            WAIT_IDLE: begin
                if (array_idle) begin
                    state_d = LOAD;
                    en_d    = 1'b1;
                    col_d   = rd_ext;
                    load_d  = CW'(1);
                end
            end
            LOAD: begin
                // load_cnt counts load cycles already on the outputs.
                if (load_cnt == CW'(ROWS)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    load_d  = '0;
                end else begin
                    en_d   = 1'b1;
                    col_d  = rd_ext;
                    load_d = load_cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fill_cnt       <= '0;
            load_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            w_ready        <= 1'b0;
            load_weight_en <= 1'b0;
            col_sum_out    <= '0;
        end else begin
            state          <= state_d;
            fill_cnt       <= fill_d;
            load_cnt       <= load_d;
            busy           <= busy_d;
            done           <= done_d;
            w_ready        <= ready_d;
            load_weight_en <= en_d;
            col_sum_out    <= col_d;
        end
    end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Scoreboard bench for pe_weight_loader, ROWS=4 COLS=2.
// Stimulus pushes expected column words; a negedge monitor pops and compares.
module tb_pe_weight_loader;

    localparam int ROWS  = 4;
    localparam int COLS  = 2;
    localparam int W_W   = 8;
    localparam int SUM_W = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  w_valid;
    logic                  w_ready;
    logic [COLS*W_W-1:0]   w_data;
    logic                  array_idle;
    logic                  load_weight_en;
    logic [COLS*SUM_W-1:0] col_sum_out;

    pe_weight_loader #(
        .ROWS(ROWS), .COLS(COLS), .W_W(W_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_data(w_data),
        .array_idle(array_idle),
        .load_weight_en(load_weight_en),
        .col_sum_out(col_sum_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];
    bit mon_on;
    int burst;
    logic [7:0] pe [ROWS][COLS];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: scoreboard pop plus a behavioural PE shift-chain model.
    always @(negedge clk) begin
        if (!mon_on || !rst_n) begin
            burst = 0;
        end else if (load_weight_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load", 64'd1, 64'd0);
            end else begin
                check("col_sum_out", col_sum_out, exp_q.pop_front());
            end
            for (int r = ROWS - 1; r > 0; r--)
                for (int c = 0; c < COLS; c++) pe[r][c] = pe[r-1][c];
            for (int c = 0; c < COLS; c++)
                pe[0][c] = col_sum_out[c*SUM_W +: W_W];
            burst++;
        end else if (burst != 0) begin
            check("burst_len", 64'(burst), 64'd4);
            check("done_after_load", 64'(done), 64'd1);
            check("col_zero_after_load", col_sum_out, 64'd0);
            burst = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("w_ready_after_start", 64'(w_ready), 64'd1);
    endtask

    task automatic push4(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic push_a();
        push4(64'h00000042_00000041, 64'h00000032_00000031,
              64'h00000022_00000021, 64'h00000012_00000011);
    endtask

    task automatic fill_tile(input logic [15:0] r0, input logic [15:0] r1,
                             input logic [15:0] r2, input logic [15:0] r3,
                             input bit stall, input bit start_mid);
        logic [15:0] rows [4];
        int k;
        int n;
        bit acc;
        rows = '{r0, r1, r2, r3};
        k = 0;
        n = 0;
        while (k < 4 && n < 200) begin
            w_valid = stall ? (n % 3 == 0) : 1'b1;
            w_data  = rows[k];
            start   = start_mid && (n == 1);
            acc     = w_valid && w_ready;
            cyc();
            if (acc) k++;
            n++;
        end
        w_valid = 1'b0;
        start   = 1'b0;
        if (n >= 200) check("fill_timeout", 64'd1, 64'd0);
    endtask

    task automatic fill_a(input bit stall, input bit start_mid);
        fill_tile(16'h1211, 16'h2221, 16'h3231, 16'h4241, stall, start_mid);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            cyc();
            n++;
        end
        if (!done) check("done_timeout", 64'd1, 64'd0);
    endtask

    logic [15:0] pe_exp [4];
    int dcnt;
    int n;

    initial begin
        pe_exp = '{16'h1211, 16'h2221, 16'h3231, 16'h4241};
        rst_n = 1'b0;
        start = 1'b0;
        w_valid = 1'b0;
        w_data = '0;
        array_idle = 1'b1;
        mon_on = 1'b1;
        burst = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pe[r][c] = 8'h00;

        repeat (2) cyc();
        check("reset_outputs",
              {busy, done, w_ready, load_weight_en, col_sum_out}, '0);
        rst_n = 1'b1;
        cyc();
        check("busy_after_reset", 64'(busy), 64'd0);
        check("w_ready_after_reset", 64'(w_ready), 64'd0);

        // Async reset while in FILL, no clock edge.
        do_start();
        rst_n = 1'b0;
        #1;
        check("async_reset_fill",
              {busy, done, w_ready, load_weight_en, col_sum_out}, '0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Basic tile.
        push_a();
        do_start();
        check("busy_in_fill", 64'(busy), 64'd1);
        fill_a(1'b0, 1'b0);
        wait_done();
        check("busy_in_done", 64'(busy), 64'd0);
        cyc();
        for (int r = 0; r < ROWS; r++)
            check($sformatf("pe_row%0d", r), {48'd0, pe[r][1], pe[r][0]},
                  {48'd0, pe_exp[r]});

        // Stalled input beats.
        push_a();
        do_start();
        fill_a(1'b1, 1'b0);
        check("w_ready_after_4th", 64'(w_ready), 64'd0);
        wait_done();
        cyc();

        // Idle gating, sign bytes, start during FILL and LOAD.
        array_idle = 1'b0;
        do_start();
        fill_tile(16'h7FF8, 16'h00FF, 16'h0180, 16'hA55A, 1'b0, 1'b1);
        repeat (10) cyc();
        check("gated_en_low", 64'(load_weight_en), 64'd0);
        check("gated_busy", 64'(busy), 64'd1);
        push4(64'h000000A5_0000005A, 64'h00000001_00000080,
              64'h00000000_000000FF, 64'h0000007F_000000F8);
        array_idle = 1'b1;
        cyc();
        check("load_next_edge", 64'(load_weight_en), 64'd1);
        array_idle = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done();
        cyc();
        check("start_in_load_ignored", {62'd0, busy, w_ready}, 64'd0);
        array_idle = 1'b1;

        // Start in the done cycle.
        push_a();
        do_start();
        fill_a(1'b0, 1'b0);
        wait_done();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_in_done_ready", 64'(w_ready), 64'd1);
        check("start_in_done_busy", 64'(busy), 64'd1);
        push_a();
        fill_a(1'b0, 1'b0);
        wait_done();
        cyc();

        // Reset during LOAD cycle 2.
        mon_on = 1'b0;
        do_start();
        fill_a(1'b0, 1'b0);
        n = 0;
        while (!load_weight_en && n < 20) begin
            cyc();
            n++;
        end
        check("reach_load", 64'(load_weight_en), 64'd1);
        repeat (2) cyc();
        rst_n = 1'b0;
        #1;
        check("reset_in_load",
              {busy, done, load_weight_en, col_sum_out}, '0);
        cyc();
        rst_n = 1'b1;
        dcnt = 0;
        repeat (8) begin
            cyc();
            if (done) dcnt++;
        end
        check("no_done_after_reset", 64'(dcnt), 64'd0);
        mon_on = 1'b1;

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_weight_loader.md
Name: pe_weight_loader

Overview:
- Initiator side of the PE weight-load protocol. Drives the broadcast `load_weight_en` and the top-of-column `in_sum` inputs of a ROWS x COLS MAC PE array.
- Accepts one row of packed 8-bit weights per handshake beat and buffers a full tile (ROWS beats).
- Waits for the array to go idle, then pushes the tile down every column in exactly ROWS back-to-back cycles, so each PE latches its own weight.
- Weight byte format: [3:0] multiplier, [7:4] shift amount. The loader treats it as opaque.

Parameters:
- ROWS, 4, number of PE rows per column (>=1)
- COLS, 4, number of PE columns
- W_W, 8, weight width per PE
- SUM_W, 32, width of the PE vertical sum path

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to load one tile
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last load cycle
- w_valid  in  1  weight beat valid
- w_ready  out  1  loader can accept a beat
- w_data  in  COLS*W_W  weights for one row; column c in bits [c*W_W +: W_W]; beat k = row k, row 0 = top
- array_idle  in  1  compute pipeline drained; safe to overwrite weights
- load_weight_en  out  1  broadcast to all PEs
- col_sum_out  out  COLS*SUM_W  top in_sum of each column; column c in [c*SUM_W +: SUM_W]

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters 0. busy=0, done=0, w_ready=0, load_weight_en=0, col_sum_out=0. The buffer contents are don't-care.
- Reset mid-load: outputs clear immediately. The PE chain holds partial weights and software must reload.
- All outputs are registered.
- FSM: IDLE -> FILL -> WAIT_IDLE -> LOAD -> IDLE.
- IDLE:
  - start=1 -> FILL; busy=1 from the next cycle.
  - start while busy is ignored.
- FILL:
  - w_ready=1.
  - On w_valid&&w_ready, store w_data into buffer row fill_cnt and increment fill_cnt.
  - Stalls (w_valid=0) are allowed and have no side effects.
  - On acceptance of beat ROWS-1: go to WAIT_IDLE; w_ready=0 from the next cycle.
  - Filling is allowed while the array is still computing (prefetch).
- WAIT_IDLE: stay until array_idle=1; then enter LOAD on the next edge.
- LOAD: runs exactly ROWS consecutive cycles with load_weight_en=1 and no gaps.
  - A gap is forbidden: with the enable low, PE out_sum becomes MAC results and corrupts in-flight weights.
  - Load cycle i (i=0..ROWS-1) drives column c with buffer[ROWS-1-i][c], zero-extended to SUM_W.
  - Upper SUM_W-W_W bits are 0, not sign-extended.
  - Reverse order ensures row r holds buffer[r] after ROWS cycles.
  - array_idle is not re-sampled during LOAD.
- Completion: the cycle after the last load cycle has load_weight_en=0, col_sum_out=0, done=1, busy=0, and state IDLE.
  - A start in that same cycle is accepted.
- Outside LOAD, col_sum_out=0, giving zero bias into the column sums during compute.
- ROWS=1: FILL takes one beat and LOAD takes one cycle.
- Counters are sized $clog2(ROWS+1) and must not wrap.

Test Plan:
- Reset: with rst_n=0 at any state, all outputs are 0 within the same cycle (no clock edge needed); after release, busy=0 and w_ready=0.
- Basic load, ROWS=4 COLS=2:
  - Stimulus: beats row0={0x11,0x12}, row1={0x21,0x22}, row2={0x31,0x32}, row3={0x41,0x42}, with array_idle=1.
  - Response: load_weight_en high for exactly 4 cycles; col0 sequence 0x41,0x31,0x21,0x11 and col1 sequence 0x42,0x32,0x22,0x12, upper 24 bits zero.
  - Then a single done pulse.
  - A behavioural 4-row PE-chain model ends with weight_reg row r = 0x(r+1)1 / 0x(r+1)2.
- Input stalls: w_valid toggling 1,0,0,1,... across FILL -> identical LOAD output to the basic case; w_ready=0 after the 4th accepted beat.
- Idle gating:
  - array_idle=0 for 10 cycles after the tile is buffered -> load_weight_en stays 0 and busy=1.
  - array_idle rising -> LOAD starts on the next edge.
  - Dropping array_idle during LOAD does not interrupt the load.
- Sign bytes: weight 0xF8 -> col_sum_out=0x000000F8, not 0xFFFFFFF8.
- Start handling:
  - start during FILL or LOAD is ignored.
  - start in the done cycle -> w_ready=1 in the next cycle.
  - rst_n pulsed low in LOAD cycle 2 -> load_weight_en=0 immediately; no done pulse.
